fir_cfg_ctrl: RTL and testbench

FIR_CFG_CTRL -- requirements
Module: fir_cfg_ctrl

---
 rtl/fir_cfg_ctrl_if.sv | 25 ++
 rtl/fir_cfg_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fir_cfg_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_cfg_ctrl_if.sv
// Host command/response bundle for the FIR configuration controller.
// One command in flight at a time; the controller answers every accepted command with a one-cycle strobe.
interface fir_cfg_ctrl_if #(
    parameter int COEF_WIDTH = 24,
    parameter int AW         = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [AW-1:0]         cmd_addr;
    logic [COEF_WIDTH-1:0] cmd_data;
    logic                  rsp_valid;
    logic [COEF_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/fir_cfg_ctrl.sv
// Sequences coefficient write/read, result-shift and flush accesses to a FIR filter core.
// Latency: wr/shift 3 (done 1 cycle after pulse), flush FLUSH_CYC+1, read 4; cmd_ready only in IDLE.
module fir_cfg_ctrl #(
    parameter int COEF_WIDTH = 24,
    parameter int COEF_COUNT = 16,
    parameter int SHIFT_W    = 5,
    parameter int TIMEOUT    = 15,
    parameter int FLUSH_CYC  = 4,
    localparam int AW        = $clog2(COEF_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_cfg_ctrl_if.slave         host,
    output logic [AW-1:0]         f_addr,
    output logic [COEF_WIDTH-1:0] f_coef,
    output logic                  f_coef_ready,
    input  logic                  f_coef_done,
    input  logic [COEF_WIDTH-1:0] f_coef_r,
    output logic                  f_shift_ready,
    output logic [SHIFT_W-1:0]    f_shift,
    input  logic                  f_shift_done,
    output logic                  f_flush,
    output logic                  busy
);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int SEQ_MAX = (FLUSH_CYC > 2) ? FLUSH_CYC : 2;
    localparam int SW      = $clog2(SEQ_MAX + 1);
    localparam int AW1     = AW + 1;

    localparam logic [TW-1:0]  TO_LIM   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  TO_SAT   = TW'(TIMEOUT);
    localparam logic [SW-1:0]  FL_LIM   = SW'(FLUSH_CYC - 1);
    localparam logic [SW-1:0]  RD_LIM   = SW'(1);
    localparam logic [AW1-1:0] ADDR_LIM = AW1'(COEF_COUNT);

    typedef enum logic [3:0] {
        IDLE, WR, WR_WAIT, SH, SH_WAIT, FLUSH, RD_ADDR, RD_CAP, RESP
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         f_addr_q, f_addr_d;
    logic [COEF_WIDTH-1:0] f_coef_q, f_coef_d;
    logic [SHIFT_W-1:0]    f_shift_q, f_shift_d;
    logic [COEF_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic [SW-1:0]         seq_cnt_q, seq_cnt_d;
    logic                  addr_bad;

    // Only reachable when COEF_COUNT is not a power of two.
    assign addr_bad = ({1'b0, host.cmd_addr} >= ADDR_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            f_addr_q   <= '0;
            f_coef_q   <= '0;
            f_shift_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
            seq_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            f_addr_q   <= f_addr_d;
            f_coef_q   <= f_coef_d;
            f_shift_q  <= f_shift_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
            seq_cnt_q  <= seq_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        f_addr_d   = f_addr_q;
        f_coef_d   = f_coef_q;
        f_shift_d  = f_shift_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        to_cnt_d   = to_cnt_q;
        seq_cnt_d  = seq_cnt_q;

        case (state_q)
            IDLE: begin
                if (host.cmd_valid) begin
                    err_d      = 1'b0;
                    rsp_data_d = '0;
                    to_cnt_d   = '0;
                    seq_cnt_d  = '0;
                    case (host.cmd_op)
                        2'b00: begin
                            if (addr_bad) begin
                                err_d   = 1'b1;
                                state_d = RESP;
                            end else begin
                                f_addr_d = host.cmd_addr;
                                f_coef_d = host.cmd_data;
                                state_d  = WR;
                            end
                        end
                        2'b01: begin
                            f_shift_d = host.cmd_data[SHIFT_W-1:0];
                            state_d   = SH;
                        end
                        2'b10: state_d = FLUSH;
                        default: begin
                            if (addr_bad) begin
                                err_d   = 1'b1;
                                state_d = RESP;
                            end else begin
                                f_addr_d = host.cmd_addr;
                                state_d  = RD_ADDR;
                            end
                        end
                    endcase
                end
            end
            WR: begin
                to_cnt_d = '0;
                state_d  = WR_WAIT;
            end
            // A done pulse in the final wait cycle still wins over the timeout.
            WR_WAIT: begin
                if (f_coef_done) begin
                    state_d = RESP;
                end else if (to_cnt_q == TO_LIM) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    to_cnt_d = (to_cnt_q == TO_SAT) ? to_cnt_q : to_cnt_q + 1'b1;
                end
            end
            SH: begin
                to_cnt_d = '0;
                state_d  = SH_WAIT;
            end
            SH_WAIT: begin
                if (f_shift_done) begin
                    state_d = RESP;
                end else if (to_cnt_q == TO_LIM) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    to_cnt_d = (to_cnt_q == TO_SAT) ? to_cnt_q : to_cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (seq_cnt_q == FL_LIM) state_d = RESP;
                else                     seq_cnt_d = seq_cnt_q + 1'b1;
            end
            // Two address cycles give the filter's coefficient readback time to settle.
            RD_ADDR: begin
                if (seq_cnt_q == RD_LIM) state_d = RD_CAP;
                else                     seq_cnt_d = seq_cnt_q + 1'b1;
            end
            RD_CAP: begin
                rsp_data_d = f_coef_r;
                state_d    = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign host.cmd_ready = (state_q == IDLE);
    assign host.rsp_valid = (state_q == RESP);
    assign host.rsp_err   = (state_q == RESP) && err_q;
    assign host.rsp_data  = (state_q == RESP) ? rsp_data_q : '0;

    assign f_addr        = f_addr_q;
    assign f_coef        = f_coef_q;
    assign f_shift       = f_shift_q;
    assign f_coef_ready  = (state_q == WR);
    assign f_shift_ready = (state_q == SH);
    assign f_flush       = (state_q == FLUSH);
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Scoreboard bench for fir_cfg_ctrl: directed commands push expected responses, a monitor pops and compares.
module tb_fir_cfg_ctrl;
    localparam int CW = 24;
    localparam int AW = 4;
    localparam int SW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] f_addr;
    logic [CW-1:0] f_coef;
    logic          f_coef_ready;
    logic          f_coef_done;
    logic [CW-1:0] f_coef_r;
    logic          f_shift_ready;
    logic [SW-1:0] f_shift;
    logic          f_shift_done;
    logic          f_flush;
    logic          busy;

    fir_cfg_ctrl_if #(.COEF_WIDTH(CW), .AW(AW)) hif ();

    fir_cfg_ctrl #(
        .COEF_WIDTH(CW), .COEF_COUNT(12), .SHIFT_W(SW), .TIMEOUT(15), .FLUSH_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .host(hif.slave),
        .f_addr(f_addr), .f_coef(f_coef), .f_coef_ready(f_coef_ready),
        .f_coef_done(f_coef_done), .f_coef_r(f_coef_r),
        .f_shift_ready(f_shift_ready), .f_shift(f_shift), .f_shift_done(f_shift_done),
        .f_flush(f_flush), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: coefficient RAM plus a done pulse done_dly cycles after each ready pulse (0 = never).
    logic [CW-1:0] mem [16];
    int  done_dly = 1;
    int  pend = 0;
    bit  pend_sh = 1'b0;
    bit  inj_done = 1'b0;

    always @(posedge clk) begin
        if (f_coef_ready) mem[f_addr] <= f_coef;
        if (f_coef_ready || f_shift_ready) begin
            pend    <= done_dly;
            pend_sh <= f_shift_ready;
        end else if (pend != 0) begin
            pend <= pend - 1;
        end
    end

    assign f_coef_r     = mem[f_addr];
    assign f_coef_done  = ((pend == 1) && !pend_sh) || inj_done;
    assign f_shift_done = ((pend == 1) && pend_sh) || inj_done;

    typedef struct {
        string         name;
        logic [CW-1:0] data;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Response monitor
    exp_t mon_e;
    always @(negedge clk) begin
        if (hif.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual data=%0h err=%0b required none", hif.rsp_data, hif.rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_data"}, 32'(hif.rsp_data), 32'(mon_e.data));
                chk({mon_e.name, "_err"}, 32'(hif.rsp_err), 32'(mon_e.err));
                chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    // Flush pulse monitor
    int fl_run = 0;
    bit fl_rdy = 1'b0;
    always @(negedge clk) begin
        if (f_flush) begin
            fl_run++;
            if (hif.cmd_ready) fl_rdy = 1'b1;
        end else if (fl_run != 0) begin
            if (!rst) begin
                chk("flush_len", 32'(fl_run), 32'd4);
                chk("flush_rdy_low", 32'(fl_rdy), 32'd0);
            end
            fl_run = 0;
            fl_rdy = 1'b0;
        end
    end

    int            rdy_cnt = 0;
    logic [AW-1:0] rdy_addr = '0;
    always @(negedge clk) begin
        if (f_coef_ready) begin
            rdy_cnt++;
            rdy_addr = f_addr;
        end
    end

    task automatic issue(input string name, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [CW-1:0] data, input logic [CW-1:0] edata,
                         input logic eerr, input int elat);
        int   n;
        exp_t e;
        @(negedge clk);
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_addr  = addr;
        hif.cmd_data  = data;
        n = 0;
        while (!hif.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_accept"}, 32'(hif.cmd_ready), 32'd1);
        if (!hif.cmd_ready) begin
            hif.cmd_valid = 1'b0;
            return;
        end
        e.name = name;
        e.data = edata;
        e.err  = eerr;
        e.lat  = elat;
        e.acc  = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        hif.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(hif.cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(hif.rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(hif.rsp_err), 32'd0);
        chk({tag, "_rsp_data"}, 32'(hif.rsp_data), 32'd0);
        chk({tag, "_f_coef_ready"}, 32'(f_coef_ready), 32'd0);
        chk({tag, "_f_shift_ready"}, 32'(f_shift_ready), 32'd0);
        chk({tag, "_f_flush"}, 32'(f_flush), 32'd0);
        chk({tag, "_f_addr"}, 32'(f_addr), 32'd0);
        chk({tag, "_f_coef"}, 32'(f_coef), 32'd0);
        chk({tag, "_f_shift"}, 32'(f_shift), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst           = 1'b1;
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = 2'b00;
        hif.cmd_addr  = '0;
        hif.cmd_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        // Write then read back through the filter model
        done_dly = 1;
        issue("wr3", 2'b00, 4'd3, 24'h000100, 24'h0, 1'b0, 3);
        drain();
        chk("wr3_ready_pulses", 32'(rdy_cnt), 32'd1);
        chk("wr3_ready_addr", 32'(rdy_addr), 32'd3);
        issue("rd3", 2'b11, 4'd3, 24'h0, 24'h000100, 1'b0, 4);
        drain();
        issue("wr11", 2'b00, 4'd11, 24'hABCDEF, 24'h0, 1'b0, 3);
        drain();
        issue("rd11", 2'b11, 4'd11, 24'h0, 24'hABCDEF, 1'b0, 4);
        drain();

        // Index beyond COEF_COUNT skips the filter
        issue("wr12_oor", 2'b00, 4'd12, 24'h777777, 24'h0, 1'b1, 1);
        drain();
        issue("rd12_oor", 2'b11, 4'd12, 24'h0, 24'h0, 1'b1, 1);
        drain();
        chk("oor_ready_pulses", 32'(rdy_cnt), 32'd2);
        chk("oor_addr_hold", 32'(f_addr), 32'd11);

        // Timeouts and the success-at-limit boundary
        done_dly = 0;
        issue("wr5_timeout", 2'b00, 4'd5, 24'h123456, 24'h0, 1'b1, 17);
        drain();
        done_dly = 1;
        issue("rd3_after_to", 2'b11, 4'd3, 24'h0, 24'h000100, 1'b0, 4);
        drain();
        done_dly = 15;
        issue("wr6_done_at_limit", 2'b00, 4'd6, 24'h000006, 24'h0, 1'b0, 17);
        drain();
        done_dly = 16;
        issue("wr7_done_late", 2'b00, 4'd7, 24'h000007, 24'h0, 1'b1, 17);
        drain();

        // Shift, then flush with a back-to-back read held behind it
        done_dly = 1;
        issue("sh7", 2'b01, 4'd0, 24'hFFFFE7, 24'h0, 1'b0, 3);
        drain();
        chk("sh7_value", 32'(f_shift), 32'd7);
        issue("flush", 2'b10, 4'd0, 24'h0, 24'h0, 1'b0, 5);
        issue("rd11_b2b", 2'b11, 4'd11, 24'h0, 24'hABCDEF, 1'b0, 4);
        drain();
        chk("shift_hold", 32'(f_shift), 32'd7);
        done_dly = 0;
        issue("sh9_timeout", 2'b01, 4'd0, 24'h000009, 24'h0, 1'b1, 17);
        drain();

        // Done pulses while idle are ignored
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("idle_done_busy", 32'(busy), 32'd0);
        chk("idle_done_ready", 32'(hif.cmd_ready), 32'd1);
        repeat (3) @(negedge clk);

        // Reset during a write's done wait
        done_dly = 1;
        issue("sh7b", 2'b01, 4'd0, 24'h000007, 24'h0, 1'b0, 3);
        drain();
        done_dly = 0;
        issue("wr2_abort", 2'b00, 4'd2, 24'h000055, 24'h0, 1'b0, 3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_wr");
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_wr_idle", 32'(busy), 32'd0);

        // Reset during flush drops f_flush at once
        issue("flush_abort", 2'b10, 4'd0, 24'h0, 24'h0, 1'b0, 5);
        @(negedge clk);
        chk("flush_active", 32'(f_flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_flush_off", 32'(f_flush), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_flush_idle", 32'(hif.cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
